// File: rtl/tri_edge_sequencer_pkg.sv
// Shared types and constants for the triangle edge sequencer: FSM state
// encoding, edge indices and the default coordinate width.
package tri_edge_sequencer_pkg;

    localparam int COORD_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] E0 = 2'd0;
    localparam logic [1:0] E1 = 2'd1;
    localparam logic [1:0] E2 = 2'd2;

endpackage

// File: rtl/tri_edge_sequencer_if.sv
// Triangle request channel: valid/ready handshake carrying three signed vertices.
interface tri_edge_sequencer_if #(
    parameter int COORD_W = 32
);
    logic                      tri_valid;
    logic                      tri_ready;
    logic signed [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;

    modport master (
        output tri_valid, vx0, vy0, vx1, vy1, vx2, vy2,
        input  tri_ready
    );

    modport slave (
        input  tri_valid, vx0, vy0, vx1, vy1, vx2, vy2,
        output tri_ready
    );
endinterface

// File: rtl/tri_edge_sequencer_edge_norm.sv
// Edge normaliser: orders an edge left-to-right and flags edges outside the
// engine's supported octant (0 <= dy <= dx).
module edge_norm #(
    parameter int COORD_W = 32
) (
    input  logic signed [COORD_W-1:0] i_ax,
    input  logic signed [COORD_W-1:0] i_ay,
    input  logic signed [COORD_W-1:0] i_bx,
    input  logic signed [COORD_W-1:0] i_by,
    output logic signed [COORD_W-1:0] o_x1,
    output logic signed [COORD_W-1:0] o_y1,
    output logic signed [COORD_W-1:0] o_x2,
    output logic signed [COORD_W-1:0] o_y2,
    output logic                      o_oct_err
);
    logic signed [COORD_W-1:0] w_x1, w_y1, w_x2, w_y2;
    logic signed [COORD_W:0]   w_dx, w_dy;

    always_comb begin
        w_x1 = i_ax;
        w_y1 = i_ay;
        w_x2 = i_bx;
        w_y2 = i_by;
        if (i_ax > i_bx) begin
            w_x1 = i_bx;
            w_y1 = i_by;
            w_x2 = i_ax;
            w_y2 = i_ay;
        end
    end

    // One extra bit so the differences of full-range coordinates never wrap
    assign w_dx = $signed({w_x2[COORD_W-1], w_x2}) - $signed({w_x1[COORD_W-1], w_x1});
    assign w_dy = $signed({w_y2[COORD_W-1], w_y2}) - $signed({w_y1[COORD_W-1], w_y1});

    assign o_x1      = w_x1;
    assign o_y1      = w_y1;
    assign o_x2      = w_x2;
    assign o_y2      = w_y2;
    assign o_oct_err = w_dy[COORD_W] || (w_dy > w_dx);
endmodule

// File: rtl/tri_edge_sequencer.sv
// Triangle edge sequencer: feeds the three edges of an accepted triangle to a
// single line engine in turn, with abort and a per-edge timeout watchdog.
module tri_edge_sequencer
    import tri_edge_sequencer_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tri_edge_sequencer_if.slave       s_tri,
    input  logic                      abort,
    output logic                      ln_start,
    output logic signed [COORD_W-1:0] ln_x1,
    output logic signed [COORD_W-1:0] ln_y1,
    output logic signed [COORD_W-1:0] ln_x2,
    output logic signed [COORD_W-1:0] ln_y2,
    input  logic                      ln_done,
    output logic [1:0]                edge_idx,
    output logic                      busy,
    output logic                      tri_done,
    output logic                      tri_err,
    output logic [2:0]                oct_err
);
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                    r_state;
    logic                      r_tri_ready, r_ln_start, r_busy, r_tri_done, r_tri_err;
    logic [1:0]                r_edge_idx;
    logic [2:0]                r_oct_err;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [COORD_W-1:0] r_vx [3];
    logic signed [COORD_W-1:0] r_vy [3];
    logic signed [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2;

    logic                      w_accept, w_timeout, w_oct;
    logic [1:0]                w_sel_idx;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic signed [COORD_W-1:0] w_v0x, w_v0y, w_v1x, w_v1y, w_v2x, w_v2y;
    logic signed [COORD_W-1:0] w_ax, w_ay, w_bx, w_by;
    logic signed [COORD_W-1:0] w_nx1, w_ny1, w_nx2, w_ny2;

    assign w_accept  = s_tri.tri_valid && r_tri_ready;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_nxt == CNT_LAST);

    // The edge being loaded: E0 straight off the request bus on accept, else the next latched edge
    always_comb begin
        w_sel_idx = (r_state == IDLE) ? E0 : r_edge_idx + 2'd1;
        w_v0x = (r_state == IDLE) ? s_tri.vx0 : r_vx[0];
        w_v0y = (r_state == IDLE) ? s_tri.vy0 : r_vy[0];
        w_v1x = (r_state == IDLE) ? s_tri.vx1 : r_vx[1];
        w_v1y = (r_state == IDLE) ? s_tri.vy1 : r_vy[1];
        w_v2x = (r_state == IDLE) ? s_tri.vx2 : r_vx[2];
        w_v2y = (r_state == IDLE) ? s_tri.vy2 : r_vy[2];
        case (w_sel_idx)
            E0:      begin w_ax = w_v0x; w_ay = w_v0y; w_bx = w_v1x; w_by = w_v1y; end
            E1:      begin w_ax = w_v1x; w_ay = w_v1y; w_bx = w_v2x; w_by = w_v2y; end
            default: begin w_ax = w_v2x; w_ay = w_v2y; w_bx = w_v0x; w_by = w_v0y; end
        endcase
    end

    edge_norm #(.COORD_W(COORD_W)) u_edge_norm (
        .i_ax      (w_ax),
        .i_ay      (w_ay),
        .i_bx      (w_bx),
        .i_by      (w_by),
        .o_x1      (w_nx1),
        .o_y1      (w_ny1),
        .o_x2      (w_nx2),
        .o_y2      (w_ny2),
        .o_oct_err (w_oct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tri_ready <= 1'b1;
            r_ln_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_tri_done  <= 1'b0;
            r_tri_err   <= 1'b0;
            r_edge_idx  <= E0;
            r_oct_err   <= 3'b000;
            r_cnt       <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
        end else begin
            r_ln_start <= 1'b0;
            r_tri_done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state     <= IDLE;
                r_tri_ready <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_vx[0]     <= s_tri.vx0;
                            r_vy[0]     <= s_tri.vy0;
                            r_vx[1]     <= s_tri.vx1;
                            r_vy[1]     <= s_tri.vy1;
                            r_vx[2]     <= s_tri.vx2;
                            r_vy[2]     <= s_tri.vy2;
                            r_edge_idx  <= E0;
                            r_oct_err   <= {2'b00, w_oct};
                            r_tri_err   <= 1'b0;
                            r_cnt       <= '0;
                            r_x1        <= w_nx1;
                            r_y1        <= w_ny1;
                            r_x2        <= w_nx2;
                            r_y2        <= w_ny2;
                            r_ln_start  <= 1'b1;
                            r_tri_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end
                    SETTLE: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_timeout) begin
                            r_tri_err  <= 1'b1;
                            r_tri_done <= 1'b1;
                            r_state    <= DONE;
                        end else if (!ln_done) begin
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (ln_done) begin
                            r_state <= NEXT;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                            if (w_timeout) begin
                                r_tri_err  <= 1'b1;
                                r_tri_done <= 1'b1;
                                r_state    <= DONE;
                            end
                        end
                    end
                    NEXT: begin
                        if (r_edge_idx == E2) begin
                            r_tri_done <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_edge_idx <= w_sel_idx;
                            r_oct_err  <= r_oct_err | ({2'b00, w_oct} << w_sel_idx);
                            r_x1       <= w_nx1;
                            r_y1       <= w_ny1;
                            r_x2       <= w_nx2;
                            r_y2       <= w_ny2;
                            r_ln_start <= 1'b1;
                            r_state    <= LAUNCH;
                        end
                    end
                    DONE: begin
                        r_tri_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                    default: begin
                        r_tri_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                endcase
            end
        end
    end

    // Abort suppresses the launch and completion pulses in the cycle it is seen
    assign ln_start        = r_ln_start & ~abort;
    assign tri_done        = r_tri_done & ~abort;
    assign s_tri.tri_ready = r_tri_ready;
    assign ln_x1           = r_x1;
    assign ln_y1           = r_y1;
    assign ln_x2           = r_x2;
    assign ln_y2           = r_y2;
    assign edge_idx        = r_edge_idx;
    assign busy            = r_busy;
    assign tri_err         = r_tri_err;
    assign oct_err         = r_oct_err;
endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Scoreboard bench for tri_edge_sequencer: a line-engine model answers each
// launch, and a monitor checks every launch and completion against a queue.
module tb_tri_edge_sequencer;
    localparam int CW  = 32;
    localparam int TMO = 16;

    logic                 clk, rst_n, abort, ln_done, ln_start;
    logic signed [CW-1:0] ln_x1, ln_y1, ln_x2, ln_y2;
    logic [1:0]           edge_idx;
    logic                 busy, tri_done, tri_err;
    logic [2:0]           oct_err;

    tri_edge_sequencer_if #(.COORD_W(CW)) tif ();

    tri_edge_sequencer #(.COORD_W(CW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tri    (tif),
        .abort    (abort),
        .ln_start (ln_start),
        .ln_x1    (ln_x1),
        .ln_y1    (ln_y1),
        .ln_x2    (ln_x2),
        .ln_y2    (ln_y2),
        .ln_done  (ln_done),
        .edge_idx (edge_idx),
        .busy     (busy),
        .tri_done (tri_done),
        .tri_err  (tri_err),
        .oct_err  (oct_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int x1, y1, x2, y2;
        int idx;
        bit err;
        int oct;
        int gap;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_fail = 0;
    int   n_launch = 0;
    int   cyc = 0, last_start = 0;
    int   tvx[3], tvy[3];
    int   eng_lat = 5, eng_stale = 0;
    bit   eng_never = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: edges v0->v1, v1->v2, v2->v0, each ordered by x, flagged when not 0<=dy<=dx
    // mode 0: full triangle, 1: timeout on E0, 2: interrupted (no completion expected)
    task automatic push_tri(input int n_launch_exp, input int mode);
        exp_t e;
        int   oct = 0;
        for (int k = 0; k < 3; k++) begin
            int a = k;
            int b = (k + 1) % 3;
            int x1 = tvx[a], y1 = tvy[a], x2 = tvx[b], y2 = tvy[b];
            if (x1 > x2) begin
                x1 = tvx[b]; y1 = tvy[b]; x2 = tvx[a]; y2 = tvy[a];
            end
            if ((y2 - y1) < 0 || (y2 - y1) > (x2 - x1)) oct |= (1 << k);
            if (k < n_launch_exp) begin
                e = '{is_done: 0, x1: x1, y1: y1, x2: x2, y2: y2, idx: k, err: 0, oct: 0, gap: -1};
                q.push_back(e);
            end
        end
        if (mode == 0) begin
            e = '{is_done: 1, x1: 0, y1: 0, x2: 0, y2: 0, idx: 2, err: 0, oct: oct, gap: -1};
            q.push_back(e);
        end else if (mode == 1) begin
            e = '{is_done: 1, x1: 0, y1: 0, x2: 0, y2: 0, idx: 0, err: 1, oct: oct & 1, gap: TMO};
            q.push_back(e);
        end
    endtask

    task automatic set_tri(input int a0, input int b0, input int a1, input int b1, input int a2, input int b2);
        tvx[0] = a0; tvy[0] = b0; tvx[1] = a1; tvy[1] = b1; tvx[2] = a2; tvy[2] = b2;
    endtask

    task automatic send_tri();
        int k = 0;
        @(negedge clk);
        while (!tif.tri_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", tif.tri_ready, 1);
        tif.tri_valid = 1'b1;
        tif.vx0 = tvx[0]; tif.vy0 = tvy[0];
        tif.vx1 = tvx[1]; tif.vy1 = tvy[1];
        tif.vx2 = tvx[2]; tif.vy2 = tvy[2];
        @(negedge clk);
        tif.tri_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk("idle_wait", busy, 0);
    endtask

    // Line-engine model: finish level drops after eng_stale cycles and rises after eng_lat
    initial begin
        int e_rise = 0, e_drop = 0;
        ln_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_rise = 0; e_drop = 0; ln_done = 1'b0;
            end else begin
                if (e_drop > 0) begin e_drop--; if (e_drop == 0) ln_done = 1'b0; end
                if (e_rise > 0) begin e_rise--; if (e_rise == 0) ln_done = 1'b1; end
                if (ln_start) begin
                    e_drop = eng_stale;
                    if (eng_stale == 0) ln_done = 1'b0;
                    e_rise = eng_never ? 0 : eng_lat;
                end
            end
        end
    end

    // Monitor: every launch and every completion must match the head of the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && ln_start) begin
                n_launch++;
                last_start = cyc;
                if (q.size() == 0) chk("unexpected_launch", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("launch_kind", e.is_done, 0);
                    chk("ln_x1", ln_x1, e.x1);
                    chk("ln_y1", ln_y1, e.y1);
                    chk("ln_x2", ln_x2, e.x2);
                    chk("ln_y2", ln_y2, e.y2);
                    chk("launch_edge_idx", edge_idx, e.idx);
                    chk("launch_busy", busy, 1);
                end
            end
            if (rst_n && tri_done) begin
                if (q.size() == 0) chk("unexpected_tri_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("done_kind", e.is_done, 1);
                    chk("tri_err", tri_err, e.err);
                    chk("oct_err", oct_err, e.oct);
                    chk("done_edge_idx", edge_idx, e.idx);
                    if (e.gap >= 0) chk("timeout_gap", cyc - last_start, e.gap);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; abort = 1'b0;
        tif.tri_valid = 1'b0;
        tif.vx0 = 0; tif.vy0 = 0; tif.vx1 = 0; tif.vy1 = 0; tif.vx2 = 0; tif.vy2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_tri_ready", tif.tri_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ln_start", ln_start, 0);
        chk("rst_tri_done", tri_done, 0);
        chk("rst_oct_err", oct_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain triangle, engine takes 5 cycles
        eng_lat = 5; eng_stale = 0; eng_never = 0;
        set_tri(1, 2, 20, 21, 30, 25);
        push_tri(3, 0); send_tri(); wait_idle();

        // Every edge outside the octant
        set_tri(10, 0, 0, 5, 5, 20);
        push_tri(3, 0); send_tri(); wait_idle();

        // Stale finish level held through launch
        eng_lat = 6; eng_stale = 2;
        set_tri(-3, 7, 12, -4, 40, 9);
        push_tri(3, 0); send_tri(); wait_idle();

        // Engine never finishes: timeout on E0
        eng_never = 1; eng_stale = 0;
        set_tri(0, 0, 8, 3, 4, 4);
        push_tri(1, 1); send_tri(); wait_idle();
        chk("tmo_no_more_launch", n_launch, 10);
        eng_never = 0;

        // Abort during WAIT of E1, then an immediate new triangle
        eng_lat = 10; eng_stale = 0;
        set_tri(10, 0, 0, 5, 5, 20);
        push_tri(2, 2);
        base = n_launch;
        send_tri();
        for (int i = 0; i < 200 && n_launch < base + 2; i++) @(negedge clk);
        chk("abort_reach_e1", n_launch, base + 2);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_tri_ready", tif.tri_ready, 1);
        chk("abort_busy", busy, 0);
        eng_lat = 5;
        set_tri(1, 2, 20, 21, 30, 25);
        push_tri(3, 0); send_tri(); wait_idle();

        // Randomized triangles, including degenerate edges
        for (int t = 0; t < 16; t++) begin
            for (int v = 0; v < 3; v++) begin
                tvx[v] = int'($urandom_range(80)) - 40;
                tvy[v] = int'($urandom_range(80)) - 40;
            end
            if ($urandom_range(3) == 0) begin tvx[1] = tvx[0]; tvy[1] = tvy[0]; end
            eng_lat = int'($urandom_range(8, 2));
            eng_stale = int'($urandom_range(eng_lat - 2));
            push_tri(3, 0); send_tri(); wait_idle();
        end

        // Asynchronous reset in LAUNCH
        eng_lat = 5; eng_stale = 0;
        set_tri(10, 0, 0, 5, 5, 20);
        push_tri(1, 2); send_tri();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ln_start", ln_start, 0);
        chk("arst_tri_ready", tif.tri_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_ln_x1", ln_x1, 0);
        chk("arst_ln_y2", ln_y2, 0);
        chk("arst_edge_idx", edge_idx, 0);
        chk("arst_oct_err", oct_err, 0);
        chk("arst_tri_err", tri_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_launch;
        repeat (30) @(negedge clk);
        chk("arst_no_relaunch", n_launch, base);
        chk("arst_idle_busy", busy, 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
